branch_predictor: RTL and testbench

//  Dynamic branch predictor feeding the pipeline control unit. Looks up a

---
 rtl/branch_predictor_pkg.sv | 26 ++
 rtl/bht_sat_counter.sv | 36 +++
 rtl/branch_predictor.sv | 96 +++++++++
 tb/tb_branch_predictor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// branch_predictor_pkg : opcodes and 2-bit counter encodings shared with control_unit
// Revision: 1.0
// ============================================================================
package branch_predictor_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam logic [1:0] BHT_INIT_DEFAULT = BHT_WNT;

    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_sat_counter.sv
`default_nettype none
// ============================================================================
// bht_sat_counter : one 2-bit saturating branch-history counter
// Revision: 1.0
// ============================================================================
module bht_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter logic [1:0] INIT_STATE = BHT_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_en,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [1:0] o_state
);

    logic [1:0] r_state;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= INIT_STATE;
        end else if (i_en) begin
            if (i_inc && !i_dec && (r_state != BHT_ST)) begin
                r_state <= r_state + 2'd1;
            end else if (i_dec && !i_inc && (r_state != BHT_SNT)) begin
                r_state <= r_state - 2'd1;
            end
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// branch_predictor : bimodal BHT lookup in IF, IF->ID prediction register,
//                    training on ID-resolved branches, branch/mispredict stats
// Revision: 1.0
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         INDEX_W    = 6,
    parameter logic [1:0] INIT_STATE = BHT_INIT_DEFAULT,
    parameter int         CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic             flush,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instr,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic             id_pred_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int c_ENTRIES = 2 ** INDEX_W;

    logic [1:0]         w_state [c_ENTRIES];
    logic [INDEX_W-1:0] w_rd_idx;
    logic [INDEX_W-1:0] w_upd_idx;
    logic               w_is_branch;
    logic               w_train;
    logic               w_unused;

    logic               r_id_pred;
    logic [CNT_W-1:0]   r_br_count;
    logic [CNT_W-1:0]   r_mis_count;

    assign w_rd_idx    = if_pc[INDEX_W+1:2];
    assign w_upd_idx   = upd_pc[INDEX_W+1:2];
    assign w_is_branch = (if_instr[6:0] == OPC_BRANCH);
    assign w_train     = upd_valid & enable;
    assign w_unused    = ^{upd_pc[31:INDEX_W+2], upd_pc[1:0]};

    // Counters are read combinationally; a same-cycle update is seen next cycle.
    generate
        for (genvar gi = 0; gi < c_ENTRIES; gi++) begin : g_bht
            bht_sat_counter #(
                .INIT_STATE (INIT_STATE)
            ) u_cnt (
                .clk     (clk),
                .arst_n  (arst_n),
                .i_en    (w_train && (w_upd_idx == INDEX_W'(gi))),
                .i_inc   (upd_taken),
                .i_dec   (!upd_taken),
                .o_state (w_state[gi])
            );
        end
    endgenerate

    assign pred_taken  = w_is_branch & w_state[w_rd_idx][1];
    assign pred_target = if_pc + b_imm(if_instr);
    assign mispredict  = w_train & (upd_taken != r_id_pred);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_id_pred   <= 1'b0;
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else begin
            // Flush squashes the ID slot even while the pipeline is stalled.
            if (flush) begin
                r_id_pred <= 1'b0;
            end else if (enable) begin
                r_id_pred <= pred_taken;
            end
            if (w_train) begin
                r_br_count <= r_br_count + CNT_W'(1);
            end
            if (mispredict) begin
                r_mis_count <= r_mis_count + CNT_W'(1);
            end
        end
    end

    assign id_pred_taken = r_id_pred;
    assign br_count      = r_br_count;
    assign mispred_count = r_mis_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// tb_branch_predictor : directed + random stimulus against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;

    logic        pred_taken, id_pred_taken, mispredict;
    logic [31:0] pred_target;
    logic [31:0] br_count, mispred_count;

    logic        p4_taken, p4_id, p4_mis;
    logic [31:0] p4_target;
    logic [3:0]  br4, mis4;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
        .if_pc(if_pc), .if_instr(if_instr), .pred_taken(pred_taken),
        .pred_target(pred_target), .id_pred_taken(id_pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .br_count(br_count), .mispred_count(mispred_count)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
        .if_pc(if_pc), .if_instr(if_instr), .pred_taken(p4_taken),
        .pred_target(p4_target), .id_pred_taken(p4_id),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(p4_mis), .br_count(br4), .mispred_count(mis4)
    );

    // ---------------- behavioural model ----------------
    int          m_bht [64];
    bit          m_id;
    int unsigned m_br, m_mis;
    bit          m_p;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit is_branch(input logic [31:0] ins);
        return ins[6:0] == 7'b1100011;
    endfunction

    function automatic bit model_pred();
        return is_branch(if_instr) && (m_bht[idx_of(if_pc)] >= 2);
    endfunction

    function automatic logic [31:0] model_target();
        int v;
        v = 2 * int'({if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8]});
        if (if_instr[31]) v = v - 8192;
        return if_pc + 32'(v);
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
        logic [31:0] im;
        im = 32'(imm);
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < 64; k++) m_bht[k] = 1;
            m_id  = 1'b0;
            m_br  = 0;
            m_mis = 0;
        end else begin
            m_p = model_pred();
            if (upd_valid && enable) begin
                if (upd_taken != m_id) m_mis = m_mis + 1;
                m_br = m_br + 1;
                if (upd_taken) m_bht[idx_of(upd_pc)] = (m_bht[idx_of(upd_pc)] == 3) ? 3 : m_bht[idx_of(upd_pc)] + 1;
                else           m_bht[idx_of(upd_pc)] = (m_bht[idx_of(upd_pc)] == 0) ? 0 : m_bht[idx_of(upd_pc)] - 1;
            end
            if (flush)       m_id = 1'b0;
            else if (enable) m_id = m_p;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("pred_taken",    64'(pred_taken),    64'(model_pred()));
        check("pred_target",   64'(pred_target),   64'(model_target()));
        check("id_pred_taken", 64'(id_pred_taken), 64'(m_id));
        check("mispredict",    64'(mispredict),    64'(upd_valid && enable && (upd_taken != m_id)));
        check("br_count",      64'(br_count),      64'(m_br));
        check("mispred_count", 64'(mispred_count), 64'(m_mis));
        check("br_count_w4",   64'(br4),           64'(m_br % 16));
        check("mispred_w4",    64'(mis4),          64'(m_mis % 16));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic en, input logic fl, input logic [31:0] pc, input logic [31:0] ins,
                       input logic uv, input logic [31:0] upc, input logic ut);
        @(posedge clk);
        #1;
        enable = en; flush = fl; if_pc = pc; if_instr = ins;
        upd_valid = uv; upd_pc = upc; upd_taken = ut;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 arst_n = 1'b0;
        enable = 1'b0; upd_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("rst_id_pred", 64'(id_pred_taken), 64'd0);
        check("rst_br",      64'(br_count),      64'd0);
        @(posedge clk);
        #2 arst_n = 1'b1;
    endtask

    logic [31:0] beq8;
    logic [31:0] r;

    initial begin
        beq8 = enc_b(8, 3'b000);
        #2 arst_n = 1'b0;
        @(negedge clk);
        check("rst_mis", 64'(mispred_count), 64'd0);
        @(posedge clk);
        #2 arst_n = 1'b1;

        // reset state lookup, then train 0x40 up and down
        cyc(1, 0, 32'h40, beq8, 0, 32'h0, 0);
        check("lit_reset_pred", 64'(pred_taken), 64'd0);
        check("lit_reset_br",   64'(br_count),   64'd0);
        cyc(1, 0, 32'h40, beq8, 1, 32'h40, 1);
        check("lit_st01", 64'(pred_taken), 64'd0);
        cyc(1, 0, 32'h40, beq8, 1, 32'h40, 1);
        check("lit_st10", 64'(pred_taken), 64'd1);
        cyc(1, 0, 32'h40, beq8, 0, 32'h0, 0);
        check("lit_st11", 64'(pred_taken), 64'd1);
        repeat (3) cyc(1, 0, 32'h40, beq8, 1, 32'h40, 0);
        cyc(1, 0, 32'h40, beq8, 0, 32'h0, 0);
        check("lit_st00", 64'(pred_taken), 64'd0);
        cyc(1, 0, 32'h40, beq8, 1, 32'h40, 0);
        cyc(1, 0, 32'h40, beq8, 1, 32'h40, 1);
        cyc(1, 0, 32'h40, beq8, 0, 32'h0, 0);
        check("lit_sat_low", 64'(pred_taken), 64'd0);

        // targets
        cyc(1, 0, 32'h100, enc_b(-8, 3'b000), 0, 32'h0, 0);
        check("lit_tgt_neg", 64'(pred_target), 64'h0F8);
        cyc(1, 0, 32'h10000, enc_b(4094, 3'b001), 0, 32'h0, 0);
        check("lit_tgt_pos", 64'(pred_target), 64'h10FFE);

        // stall / flush
        cyc(1, 0, 32'h0, NOP, 1, 32'h80, 1);
        cyc(1, 0, 32'h0, NOP, 1, 32'h80, 1);
        cyc(1, 0, 32'h80, beq8, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, NOP, 1, 32'h80, 0);
        check("lit_id_taken", 64'(id_pred_taken), 64'd1);
        check("lit_stall_mis", 64'(mispredict), 64'd0);
        cyc(0, 0, 32'h0, NOP, 1, 32'h80, 0);
        check("lit_stall_hold", 64'(id_pred_taken), 64'd1);
        cyc(0, 1, 32'h0, NOP, 0, 32'h0, 0);
        cyc(0, 0, 32'h80, beq8, 0, 32'h0, 0);
        check("lit_flush", 64'(id_pred_taken), 64'd0);
        check("lit_stall_notrain", 64'(pred_taken), 64'd1);

        // same-index read/train, after a mid-operation reset
        do_reset();
        cyc(1, 0, 32'h14, beq8, 1, 32'h14, 1);
        check("lit_rw_same", 64'(pred_taken), 64'd0);
        cyc(1, 0, 32'h14, beq8, 0, 32'h0, 0);
        check("lit_rw_next", 64'(pred_taken), 64'd1);

        // stats: 10 branches, 3 mispredicted, then wrap on the 4-bit instance
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1, 0, 32'h0, NOP, 1, 32'(k * 4), (k < 3));
        cyc(1, 0, 32'h0, NOP, 0, 32'h0, 0);
        check("lit_br10",  64'(br_count),      64'd10);
        check("lit_mis3",  64'(mispred_count), 64'd3);
        for (int k = 0; k < 7; k++) cyc(1, 0, 32'h0, NOP, 1, 32'h200, 0);
        cyc(1, 0, 32'h0, NOP, 0, 32'h0, 0);
        check("lit_br17",  64'(br_count), 64'd17);
        check("lit_wrap4", 64'(br4),      64'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clk);
                #1 arst_n = 1'b0;
                @(posedge clk);
                #3 arst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            r = $urandom();
            enable = ($urandom_range(0, 9) < 8);
            flush  = ($urandom_range(0, 9) == 0);
            if_pc  = {r[31:10], ($urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : r[7:2]), 2'b00};
            r = $urandom();
            if_instr = ($urandom_range(0, 9) < 6) ? {r[31:7], 7'b1100011} : r;
            upd_valid = $urandom_range(0, 1);
            upd_taken = $urandom_range(0, 1);
            r = $urandom();
            upd_pc = ($urandom_range(0, 3) == 0) ? if_pc
                   : {r[31:8], 4'b0, 2'($urandom_range(0, 3)), 2'b00};
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
